// File: rtl/trans_buffers_pkg.sv
// ----------------------------------------------------------------------------
// trans_buffers_pkg
// Shared constants and width helpers for the lane transfer buffers.
//   DEFAULT_LANE_WIDTH : default data bits per lane
//   DEFAULT_DEPTH      : default entries per lane FIFO
//   strb_width()       : byte-strobe bits for one lane
//   level_width()      : bits needed to hold an occupancy of 0..depth
// ----------------------------------------------------------------------------
package trans_buffers_pkg;

  localparam int DEFAULT_LANE_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 4;

  function automatic int strb_width(input int lane_width);
    return lane_width / 8;
  endfunction

  // An occupancy counter must represent both 0 and depth, hence depth+1.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/trans_lane_fifo.sv
// ----------------------------------------------------------------------------
// trans_lane_fifo
// Single-lane FIFO with req/gnt handshakes on both sides.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : synchronous clear of pointers/count; blocks all grants
//   push_dat_i/req/gnt: write side, gnt = not full
//   pop_dat_o/req/gnt : read side, gnt = not empty, data = head entry
//   count_o           : current occupancy 0..DEPTH
// Any DEPTH >= 1 is supported; pointers wrap explicitly at DEPTH-1.
// ----------------------------------------------------------------------------
module trans_lane_fifo
  import trans_buffers_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_LANE_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [DATA_WIDTH-1:0]         push_dat_i,
  input  logic                          push_req_i,
  output logic                          push_gnt_o,
  output logic [DATA_WIDTH-1:0]         pop_dat_o,
  input  logic                          pop_req_i,
  output logic                          pop_gnt_o,
  output logic [level_width(DEPTH)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [CNT_W-1:0]      count_reg;

  logic full;
  logic empty;
  logic blocked;
  logic push_fire;
  logic pop_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  // Reset and flush both withhold grants so no handshake can complete
  // in a cycle whose state update is discarded anyway.
  assign blocked = rst_i | flush_i;

  assign push_gnt_o = ~blocked & ~full;
  assign pop_gnt_o  = ~blocked & ~empty;
  assign push_fire  = push_req_i & push_gnt_o;
  assign pop_fire   = pop_req_i & pop_gnt_o;

  // Head entry straight from storage; only meaningful while pop_gnt_o=1.
  assign pop_dat_o = mem[rd_ptr_reg];
  assign count_o   = count_reg;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      mem[wr_ptr_reg] <= push_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop_fire) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push_fire, pop_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/trans_buffers_lanes.sv
// ----------------------------------------------------------------------------
// trans_buffers_lanes
// N_LANES independent TX and RX lane FIFOs between a per-lane TCDM side and
// a wide lockstep EXT side.
//   clk_i, rst_i, flush_i           : clock, sync reset, sync flush
//   tx_push_dat_i/req_i/gnt_o       : TCDM -> TX lanes, per-lane handshake
//   tx_pop_dat_o/req_i/gnt_o        : TX lanes -> EXT, one wide word
//   rx_push_dat_i/strb_i/req_i/gnt_o: EXT -> RX lanes, one wide word
//   rx_pop_dat_o/strb_o/req_i/gnt_o : RX lanes -> TCDM, per-lane handshake
// Lane k occupies bits [k*LANE_WIDTH +: LANE_WIDTH] (strobes [k*LANE_WIDTH/8
// +: LANE_WIDTH/8]); lane 0 is in the LSBs.
// Optional macro TRANS_BUFFERS_LEVEL_EN adds tx_level_o / rx_level_o, the
// minimum occupancy across the TX / RX lanes.
// ----------------------------------------------------------------------------
module trans_buffers_lanes
  import trans_buffers_pkg::*;
#(
  parameter int N_LANES    = 2,
  parameter int LANE_WIDTH = DEFAULT_LANE_WIDTH,
  parameter int TX_DEPTH   = DEFAULT_DEPTH,
  parameter int RX_DEPTH   = DEFAULT_DEPTH
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  input  logic [N_LANES*LANE_WIDTH-1:0]               tx_push_dat_i,
  input  logic [N_LANES-1:0]                          tx_push_req_i,
  output logic [N_LANES-1:0]                          tx_push_gnt_o,
  output logic [N_LANES*LANE_WIDTH-1:0]               rx_pop_dat_o,
  output logic [N_LANES*strb_width(LANE_WIDTH)-1:0]   rx_pop_strb_o,
  input  logic [N_LANES-1:0]                          rx_pop_req_i,
  output logic [N_LANES-1:0]                          rx_pop_gnt_o,
  output logic [N_LANES*LANE_WIDTH-1:0]               tx_pop_dat_o,
  input  logic                                        tx_pop_req_i,
  output logic                                        tx_pop_gnt_o,
  input  logic [N_LANES*LANE_WIDTH-1:0]               rx_push_dat_i,
  input  logic [N_LANES*strb_width(LANE_WIDTH)-1:0]   rx_push_strb_i,
  input  logic                                        rx_push_req_i,
  output logic                                        rx_push_gnt_o
`ifdef TRANS_BUFFERS_LEVEL_EN
  ,
  output logic [level_width(TX_DEPTH)-1:0]            tx_level_o,
  output logic [level_width(RX_DEPTH)-1:0]            rx_level_o
`endif
);

  localparam int SW  = strb_width(LANE_WIDTH);
  localparam int RXW = LANE_WIDTH + SW;
  localparam int TLW = level_width(TX_DEPTH);
  localparam int RLW = level_width(RX_DEPTH);

  logic [N_LANES-1:0]            tx_pop_gnt_lane;
  logic [N_LANES-1:0]            rx_push_gnt_lane;
  logic [N_LANES-1:0][TLW-1:0]   tx_count;
  logic [N_LANES-1:0][RLW-1:0]   rx_count;
  logic [N_LANES-1:0][RXW-1:0]   rx_pop_word;
  logic                          tx_pop_fire;
  logic                          rx_push_fire;

  // The EXT side moves a full word only when every lane can take part.
  // Lane grants never depend on requests, so this AND has no loop.
  assign tx_pop_gnt_o  = &tx_pop_gnt_lane;
  assign rx_push_gnt_o = &rx_push_gnt_lane;

  // Fan the lockstep handshake out as the per-lane request, so a lane
  // only moves when all of them do.
  assign tx_pop_fire  = tx_pop_req_i & tx_pop_gnt_o;
  assign rx_push_fire = rx_push_req_i & rx_push_gnt_o;

  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      trans_lane_fifo #(
        .DATA_WIDTH (LANE_WIDTH),
        .DEPTH      (TX_DEPTH)
      ) u_tx_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .push_dat_i (tx_push_dat_i[gi*LANE_WIDTH +: LANE_WIDTH]),
        .push_req_i (tx_push_req_i[gi]),
        .push_gnt_o (tx_push_gnt_o[gi]),
        .pop_dat_o  (tx_pop_dat_o[gi*LANE_WIDTH +: LANE_WIDTH]),
        .pop_req_i  (tx_pop_fire),
        .pop_gnt_o  (tx_pop_gnt_lane[gi]),
        .count_o    (tx_count[gi])
      );

      // RX entries carry the strobes in the upper bits: {strb, data}.
      trans_lane_fifo #(
        .DATA_WIDTH (RXW),
        .DEPTH      (RX_DEPTH)
      ) u_rx_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .push_dat_i ({rx_push_strb_i[gi*SW +: SW],
                      rx_push_dat_i[gi*LANE_WIDTH +: LANE_WIDTH]}),
        .push_req_i (rx_push_fire),
        .push_gnt_o (rx_push_gnt_lane[gi]),
        .pop_dat_o  (rx_pop_word[gi]),
        .pop_req_i  (rx_pop_req_i[gi]),
        .pop_gnt_o  (rx_pop_gnt_o[gi]),
        .count_o    (rx_count[gi])
      );

      assign rx_pop_dat_o[gi*LANE_WIDTH +: LANE_WIDTH] = rx_pop_word[gi][LANE_WIDTH-1:0];
      assign rx_pop_strb_o[gi*SW +: SW]                = rx_pop_word[gi][RXW-1:LANE_WIDTH];
    end
  endgenerate

`ifdef TRANS_BUFFERS_LEVEL_EN
  // Minimum occupancy = number of complete wide words available (TX) or
  // guaranteed free-side depth consumed (RX).
  always_comb begin
    tx_level_o = tx_count[0];
    for (int k = 1; k < N_LANES; k++) begin
      if (tx_count[k] < tx_level_o) begin
        tx_level_o = tx_count[k];
      end
    end
  end

  always_comb begin
    rx_level_o = rx_count[0];
    for (int k = 1; k < N_LANES; k++) begin
      if (rx_count[k] < rx_level_o) begin
        rx_level_o = rx_count[k];
      end
    end
  end
`else
  // Occupancy counts have no consumer without the level outputs; this sink
  // keeps them visibly intentional and is trimmed away in synthesis.
  logic unused_counts;
  assign unused_counts = ^{tx_count, rx_count};
`endif

endmodule

// File: tb/tb_trans_buffers_lanes.sv
// ----------------------------------------------------------------------------
// tb_trans_buffers_lanes
// Scoreboard bench: per-lane queues model every FIFO; grants, EXT words and
// RX lane pops are compared against the queues each cycle. A second instance
// with TX_DEPTH=3 exercises non-power-of-two pointer wrap.
// ----------------------------------------------------------------------------
module tb_trans_buffers_lanes;

  localparam int N    = 2;
  localparam int LW   = 32;
  localparam int SW   = LW / 8;
  localparam int TXD  = 4;
  localparam int RXD  = 4;
  localparam int TXD3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             flush;
  logic [N*LW-1:0]  tx_push_dat;
  logic [N-1:0]     tx_push_req;
  logic [N-1:0]     tx_push_gnt;
  logic [N*LW-1:0]  rx_pop_dat;
  logic [N*SW-1:0]  rx_pop_strb;
  logic [N-1:0]     rx_pop_req;
  logic [N-1:0]     rx_pop_gnt;
  logic [N*LW-1:0]  tx_pop_dat;
  logic             tx_pop_req;
  logic             tx_pop_gnt;
  logic [N*LW-1:0]  rx_push_dat;
  logic [N*SW-1:0]  rx_push_strb;
  logic             rx_push_req;
  logic             rx_push_gnt;

  // second instance (TX_DEPTH=3), TX path only
  logic             w_flush;
  logic [N*LW-1:0]  w_tx_push_dat;
  logic [N-1:0]     w_tx_push_req;
  logic [N-1:0]     w_tx_push_gnt;
  logic [N*LW-1:0]  w_rx_pop_dat;
  logic [N*SW-1:0]  w_rx_pop_strb;
  logic [N-1:0]     w_rx_pop_req;
  logic [N-1:0]     w_rx_pop_gnt;
  logic [N*LW-1:0]  w_tx_pop_dat;
  logic             w_tx_pop_req;
  logic             w_tx_pop_gnt;
  logic [N*LW-1:0]  w_rx_push_dat;
  logic [N*SW-1:0]  w_rx_push_strb;
  logic             w_rx_push_req;
  logic             w_rx_push_gnt;

`ifdef TRANS_BUFFERS_LEVEL_EN
  logic [$clog2(TXD+1)-1:0]  tx_level;
  logic [$clog2(RXD+1)-1:0]  rx_level;
  logic [$clog2(TXD3+1)-1:0] w_tx_level;
  logic [$clog2(RXD+1)-1:0]  w_rx_level;
`endif

  trans_buffers_lanes #(
    .N_LANES (N), .LANE_WIDTH (LW), .TX_DEPTH (TXD), .RX_DEPTH (RXD)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .tx_push_dat_i  (tx_push_dat),
    .tx_push_req_i  (tx_push_req),
    .tx_push_gnt_o  (tx_push_gnt),
    .rx_pop_dat_o   (rx_pop_dat),
    .rx_pop_strb_o  (rx_pop_strb),
    .rx_pop_req_i   (rx_pop_req),
    .rx_pop_gnt_o   (rx_pop_gnt),
    .tx_pop_dat_o   (tx_pop_dat),
    .tx_pop_req_i   (tx_pop_req),
    .tx_pop_gnt_o   (tx_pop_gnt),
    .rx_push_dat_i  (rx_push_dat),
    .rx_push_strb_i (rx_push_strb),
    .rx_push_req_i  (rx_push_req),
    .rx_push_gnt_o  (rx_push_gnt)
`ifdef TRANS_BUFFERS_LEVEL_EN
    ,
    .tx_level_o     (tx_level),
    .rx_level_o     (rx_level)
`endif
  );

  trans_buffers_lanes #(
    .N_LANES (N), .LANE_WIDTH (LW), .TX_DEPTH (TXD3), .RX_DEPTH (RXD)
  ) u_dut3 (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (w_flush),
    .tx_push_dat_i  (w_tx_push_dat),
    .tx_push_req_i  (w_tx_push_req),
    .tx_push_gnt_o  (w_tx_push_gnt),
    .rx_pop_dat_o   (w_rx_pop_dat),
    .rx_pop_strb_o  (w_rx_pop_strb),
    .rx_pop_req_i   (w_rx_pop_req),
    .rx_pop_gnt_o   (w_rx_pop_gnt),
    .tx_pop_dat_o   (w_tx_pop_dat),
    .tx_pop_req_i   (w_tx_pop_req),
    .tx_pop_gnt_o   (w_tx_pop_gnt),
    .rx_push_dat_i  (w_rx_push_dat),
    .rx_push_strb_i (w_rx_push_strb),
    .rx_push_req_i  (w_rx_push_req),
    .rx_push_gnt_o  (w_rx_push_gnt)
`ifdef TRANS_BUFFERS_LEVEL_EN
    ,
    .tx_level_o     (w_tx_level),
    .rx_level_o     (w_rx_level)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [LW-1:0]    tx_q [N][$];
  logic [SW+LW-1:0] rx_q [N][$];
  logic [N*LW-1:0]  w_q [$];

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    tx_push_req = '0;
    tx_pop_req  = 1'b0;
    rx_push_req = 1'b0;
    rx_pop_req  = '0;
  endtask

  // Called at a falling edge with inputs already driven: compare outputs to
  // the model, apply the handshakes that complete at the next rising edge.
  task automatic tick();
    logic            blk;
    logic            all_tx;
    logic            all_rx;
    logic [N-1:0]    exp_tx_push;
    logic [N-1:0]    exp_rx_pop;
    logic [N*LW-1:0] exp_word;
    logic [SW+LW-1:0] e;
    #1;
    blk    = rst | flush;
    all_tx = ~blk;
    all_rx = ~blk;
    for (int k = 0; k < N; k++) begin
      if (tx_q[k].size() == 0)   all_tx = 1'b0;
      if (rx_q[k].size() == RXD) all_rx = 1'b0;
      exp_tx_push[k] = ~blk && (tx_q[k].size() < TXD);
      exp_rx_pop[k]  = ~blk && (rx_q[k].size() > 0);
    end
    check_val("tx_pop_gnt",  128'(tx_pop_gnt),  128'(all_tx));
    check_val("rx_push_gnt", 128'(rx_push_gnt), 128'(all_rx));
    check_val("tx_push_gnt", 128'(tx_push_gnt), 128'(exp_tx_push));
    check_val("rx_pop_gnt",  128'(rx_pop_gnt),  128'(exp_rx_pop));
`ifdef TRANS_BUFFERS_LEVEL_EN
    begin
      int mt, mr;
      mt = tx_q[0].size();
      mr = rx_q[0].size();
      for (int k = 1; k < N; k++) begin
        if (tx_q[k].size() < mt) mt = tx_q[k].size();
        if (rx_q[k].size() < mr) mr = rx_q[k].size();
      end
      check_val("tx_level", 128'(tx_level), 128'(mt));
      check_val("rx_level", 128'(rx_level), 128'(mr));
    end
`endif
    if (blk) begin
      for (int k = 0; k < N; k++) begin
        tx_q[k].delete();
        rx_q[k].delete();
      end
    end else begin
      if (all_tx && tx_pop_req) begin
        for (int k = 0; k < N; k++) exp_word[k*LW +: LW] = tx_q[k].pop_front();
        check_val("tx_pop_dat", 128'(tx_pop_dat), 128'(exp_word));
      end
      for (int k = 0; k < N; k++) begin
        if (exp_rx_pop[k] && rx_pop_req[k]) begin
          e = rx_q[k].pop_front();
          check_val("rx_pop_dat",  128'(rx_pop_dat[k*LW +: LW]),  128'(e[LW-1:0]));
          check_val("rx_pop_strb", 128'(rx_pop_strb[k*SW +: SW]), 128'(e[SW+LW-1:LW]));
        end
        if (exp_tx_push[k] && tx_push_req[k]) tx_q[k].push_back(tx_push_dat[k*LW +: LW]);
      end
      if (all_rx && rx_push_req) begin
        for (int k = 0; k < N; k++)
          rx_q[k].push_back({rx_push_strb[k*SW +: SW], rx_push_dat[k*LW +: LW]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    tx_push_dat = '0; rx_push_dat = '0; rx_push_strb = '0;
    idle();
    w_flush = 1'b0; w_tx_push_dat = '0; w_tx_push_req = '0; w_tx_pop_req = 1'b0;
    w_rx_pop_req = '0; w_rx_push_dat = '0; w_rx_push_strb = '0; w_rx_push_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();  // post-reset grants

    // Lockstep word from two lanes pushed together.
    tx_push_dat = {32'h22222222, 32'h11111111};
    tx_push_req = 2'b11;
    tick(); idle();
    #1;
    check_val("ext_word_ready", 128'(tx_pop_gnt), 128'(1));
    check_val("ext_word_value", 128'(tx_pop_dat), 128'(64'h22222222_11111111));
    tx_pop_req = 1'b1;
    tick(); idle();
    tick();

    // Lane 0 filled alone; 5th push attempt must be refused.
    for (int j = 0; j < TXD + 1; j++) begin
      tx_push_dat[LW-1:0] = 32'h3000_0000 + 32'(j);
      tx_push_req = 2'b01;
      tx_pop_req  = 1'b1;  // never granted: lane 1 is empty
      tick();
    end
    idle();
    tx_push_dat[2*LW-1:LW] = 32'h4000_0040;
    tx_push_req = 2'b10;
    tick(); idle();
    tick();  // one EXT word ready, level 1

    // EXT push with strobes split across lanes.
    rx_push_dat  = 64'hAABBCCDD_01020304;
    rx_push_strb = 8'hF0;
    rx_push_req  = 1'b1;
    tick(); idle();
    #1;
    check_val("rx_lane0_dat",  128'(rx_pop_dat[31:0]),   128'(32'h01020304));
    check_val("rx_lane0_strb", 128'(rx_pop_strb[3:0]),   128'(4'h0));
    check_val("rx_lane1_dat",  128'(rx_pop_dat[63:32]),  128'(32'hAABBCCDD));
    check_val("rx_lane1_strb", 128'(rx_pop_strb[7:4]),   128'(4'hF));
    rx_pop_req = 2'b11;
    tick(); idle();

    // Fill RX, then push against full while lane 0 drains.
    for (int j = 0; j < RXD; j++) begin
      rx_push_dat  = {$urandom, $urandom};
      rx_push_strb = 8'($urandom);
      rx_push_req  = 1'b1;
      tick();
    end
    rx_pop_req = 2'b01;
    tick();
    rx_pop_req = 2'b00;
    tick();  // lane 1 still full: push still refused
    rx_pop_req = 2'b10;
    tick();
    rx_pop_req = 2'b00;
    tick();  // push accepted now
    idle();

    // Flush with words queued and every request active.
    tx_push_req = 2'b11; tx_pop_req = 1'b1; rx_push_req = 1'b1; rx_pop_req = 2'b11;
    flush = 1'b1;
    tick();
    flush = 1'b0; idle();
    tick();

    // Reset in the middle of a stream.
    for (int j = 0; j < 3; j++) begin
      tx_push_dat = {32'h5000_0000 + 32'(j), 32'h6000_0000 + 32'(j)};
      tx_push_req = 2'b11;
      rx_push_dat = {$urandom, $urandom};
      rx_push_req = 1'b1;
      tick();
    end
    tx_pop_req = 1'b1; rx_pop_req = 2'b11;
    rst = 1'b1;
    tick();
    rst = 1'b0; idle();
    tick();

    // Non-power-of-two depth wrap on the second instance.
    for (int i = 0; i < 14; i++) begin
      logic            exp_pg;
      logic            exp_pp;
      logic [N*LW-1:0] d;
      d = {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
      w_tx_push_dat = d;
      w_tx_push_req = 2'b11;
      w_tx_pop_req  = i[0];
      #1;
      exp_pg = (w_q.size() < TXD3);
      exp_pp = (w_q.size() > 0);
      check_val("wrap_push_gnt", 128'(w_tx_push_gnt), 128'({N{exp_pg}}));
      check_val("wrap_pop_gnt",  128'(w_tx_pop_gnt),  128'(exp_pp));
      if (exp_pp && w_tx_pop_req) check_val("wrap_pop_dat", 128'(w_tx_pop_dat), 128'(w_q.pop_front()));
      if (exp_pg) w_q.push_back(d);
      @(posedge clk);
      @(negedge clk);
    end
    w_tx_push_req = '0;
    w_tx_pop_req  = 1'b0;

    // Random traffic on the main instance.
    for (int i = 0; i < 80; i++) begin
      tx_push_dat  = {$urandom, $urandom};
      rx_push_dat  = {$urandom, $urandom};
      rx_push_strb = 8'($urandom);
      tx_push_req  = 2'($urandom);
      tx_pop_req   = 1'($urandom);
      rx_push_req  = 1'($urandom);
      rx_pop_req   = 2'($urandom);
      flush        = ($urandom_range(15) == 0);
      tick();
    end
    flush = 1'b0; idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trans_buffers_lanes.md
Name: trans_buffers_lanes

Overview:
- Parametrised successor of the two-lane TX/RX transfer buffer pair between the TCDM side and the EXT side of the mini DMA channel.
- Provides N_LANES independent per-lane FIFOs. The TCDM side uses per-lane req/gnt. The EXT side uses one wide lockstep word of N_LANES*LANE_WIDTH bits.
- Adds over the previous generation: generic lane count, width and depth; synchronous flush; per-direction word-count status.

Parameters:
- N_LANES, 2, number of lanes; at least 1.
- LANE_WIDTH, 32, data bits per lane; multiple of 8.
- TX_DEPTH, 4, entries per TX lane FIFO; at least 1; any integer, power of 2 not required.
- RX_DEPTH, 4, entries per RX lane FIFO; at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- flush_i  in  1  clears all FIFOs.
- tx_push_dat_i  in  N_LANES*LANE_WIDTH  TCDM write data, lane k at bits [k*LANE_WIDTH +: LANE_WIDTH].
- tx_push_req_i  in  N_LANES  per-lane push request.
- tx_push_gnt_o  out  N_LANES  per-lane push grant.
- rx_pop_dat_o  out  N_LANES*LANE_WIDTH  TCDM read data, per lane.
- rx_pop_strb_o  out  N_LANES*LANE_WIDTH/8  byte strobes, per lane.
- rx_pop_req_i  in  N_LANES  per-lane pop request.
- rx_pop_gnt_o  out  N_LANES  per-lane pop grant.
- tx_pop_dat_o  out  N_LANES*LANE_WIDTH  EXT read word.
- tx_pop_req_i  in  1  EXT pop request.
- tx_pop_gnt_o  out  1  EXT pop grant.
- rx_push_dat_i  in  N_LANES*LANE_WIDTH  EXT write word.
- rx_push_strb_i  in  N_LANES*LANE_WIDTH/8  EXT byte strobes.
- rx_push_req_i  in  1  EXT push request.
- rx_push_gnt_o  out  1  EXT push grant.
- Interface rule: one clock (clk_i); reset rst_i is synchronous and active-high.

Behaviour:
- Handshake: a transfer occurs on a rising edge where req=1 and gnt=1.
  - Push gnt = FIFO not full. Pop gnt = FIFO not empty.
  - Gnt never depends on req. Req without gnt is ignored; no state change.
- Per-lane FIFO:
  - Registered storage, read pointer, write pointer, count register 0..DEPTH.
  - Pointers wrap from DEPTH-1 to 0.
  - Pop data is the head entry, driven combinationally from storage. It is valid only while pop gnt=1 and is don't-care otherwise.
- Latency: a word pushed at edge N is visible at the pop side after edge N, i.e. 1 cycle. There is no bypass; an empty FIFO never grants pop in the same cycle as a push.
- Simultaneous push and pop on one lane: both occur, count unchanged.
  - At full: only the pop is granted; the push gnt is 0.
  - At empty: only the push occurs.
- RX lane FIFOs store {strb, data}, width LANE_WIDTH+LANE_WIDTH/8.
- EXT side lockstep:
  - tx_pop_gnt_o = AND of all TX lane pop-gnts. An EXT pop pops every TX lane in the same cycle. TX lanes never pop individually.
  - rx_push_gnt_o = AND of all RX lane push-gnts. An EXT push writes every RX lane in the same cycle.
  - Lane order: lane 0 occupies the LSBs of the wide words and of the strobes.
- Lanes are filled and drained independently on the TCDM side. The EXT word becomes available when the slowest lane has data.
- Reset (rst_i=1 at an edge), including mid-transfer:
  - All pointers and counts go to 0; storage contents are not reset.
  - After that edge: tx_push_gnt_o all 1, rx_push_gnt_o=1, tx_pop_gnt_o=0, rx_pop_gnt_o all 0.
  - During the reset cycle, any req is discarded.
- flush_i=1 at an edge: same effect as reset on pointers and counts. All gnt outputs are forced to 0 in that cycle, so no transfer completes. rst_i has priority over flush_i.

Optional Feature:
- Macro: TRANS_BUFFERS_LEVEL_EN.
- When defined, two extra outputs are present:
  - tx_level_o, width clog2(TX_DEPTH+1): minimum count over the TX lanes, i.e. number of full EXT words ready.
  - rx_level_o, width clog2(RX_DEPTH+1): minimum count over the RX lanes.
  - Both are combinational from the count registers and 0 after reset or flush.
- When not defined: the ports are absent and no comparator logic is present. Behaviour is otherwise identical.

Decomposition:
- Package trans_buffers_pkg:
  - localparams for default lane width and default depth.
  - strobe-width function (LANE_WIDTH/8).
  - level-width function (clog2(DEPTH+1)).
- Sub-module trans_lane_fifo: ports DATA_WIDTH, DEPTH, clk_i, rst_i, flush_i, push and pop handshakes, count_o.
- Top level: generate loops over lanes, the lockstep AND/req fan-out, and optional min-level trees.

Test Plan:
- Reset, then push 0x11111111 on lane0 and 0x22222222 on lane1 in the same cycle -> tx_pop_gnt_o=1 next cycle, tx_pop_dat_o=0x22222222_11111111. Pop it -> tx_pop_gnt_o=0.
- Push 4 words on lane0 only (TX_DEPTH=4) -> tx_push_gnt_o[0]=0 after the 4th; tx_pop_gnt_o stays 0. Push 1 on lane1 -> tx_pop_gnt_o=1; tx_level_o=1.
- EXT push dat=0xAABBCCDD_01020304, strb=0xF0 -> lane0 pops 0x01020304 with strb 0x0; lane1 pops 0xAABBCCDD with strb 0xF.
- Fill RX to 4 words, then drive simultaneous rx_push_req_i and a lane0 pop -> push refused (rx_push_gnt_o=0), lane0 count goes to 3. Next cycle rx_push_gnt_o stays 0 until lane1 is also popped.
- Assert flush_i with 2 words queued plus active reqs -> all gnts 0 that cycle; next cycle counts 0, pop gnts 0, push gnts 1.
- Assert rst_i mid-stream with 3 words queued -> identical post-reset state. Then run 10 wrap-around cycles with TX_DEPTH=3 -> data order preserved.
